// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// access-size codes, parameter defaults and the alignment rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PIPE = 2'b01,
        S_DMA  = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int ACK_TIMEOUT_DEF  = 15;

    // Size code 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Word-wide memory bus driven by the arbiter (master) towards the data RAM (slave).
interface data_mem_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/data_mem_arbiter_lane_align.sv
// Byte-lane steering for sub-word pipeline accesses: store lanes and enables,
// load extraction with zero extension, and the misalignment flag.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic        misalign_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    assign misalign_o = is_misaligned(size_i, off_i);

    // Store side: replicate the datum across all lanes and enable only the addressed ones.
    always_comb begin
        be_o      = 4'b1111;
        st_data_o = st_data_i;
        case (size_i)
            SZ_BYTE: begin
                be_o      = 4'b0001 << off_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o      = off_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
            end
            default: begin
                be_o      = 4'b1111;
                st_data_o = st_data_i;
            end
        endcase
    end

    // Load side: right-justify the addressed lane(s).
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = {24'h00_0000, ld_raw_i[{ld_off_i, 3'b000} +: 8]};
            SZ_HALF: ld_data_o = ld_off_i[1] ? {16'h0000, ld_raw_i[31:16]}
                                             : {16'h0000, ld_raw_i[15:0]};
            default: ld_data_o = ld_raw_i;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates one data memory between the MEM pipeline stage and a DMA port,
// with starvation protection for DMA and an ack timeout on every access.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rt_i,
    input  logic [1:0]  bit_sel_i,
    output logic        pipe_stall_o,
    output logic        pipe_done_o,
    output logic [31:0] pipe_rdata_o,
    output logic        misalign_err_o,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_gnt_o,
    output logic        dma_done_o,
    output logic [31:0] dma_rdata_o,
    data_mem_arbiter_if.master mem
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [1:0]      ld_size_q, ld_size_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic            pipe_done_q, pipe_done_d;
    logic [31:0]     pipe_rdata_q, pipe_rdata_d;
    logic            misalign_q, misalign_d;
    logic            dma_done_q, dma_done_d;
    logic [31:0]     dma_rdata_q, dma_rdata_d;

    logic            pipe_req_s, ack_s, tmo_hit_s, dma_win_s;
    logic            pipe_gnt_s, dma_gnt_s, misalign_s;
    logic [3:0]      be_s;
    logic [31:0]     st_data_s, ld_data_s;
    logic            unused_dma_addr_s;

    assign unused_dma_addr_s = ^dma_addr_i[1:0];

    mem_lane_align u_lane (
        .size_i     (bit_sel_i),
        .off_i      (alu_result_i[1:0]),
        .st_data_i  (rt_i),
        .be_o       (be_s),
        .st_data_o  (st_data_s),
        .misalign_o (misalign_s),
        .ld_size_i  (ld_size_q),
        .ld_off_i   (ld_off_q),
        .ld_raw_i   (mem.mem_rdata),
        .ld_data_o  (ld_data_s)
    );

    assign pipe_req_s = mem_read_i | mem_write_i;
    assign ack_s      = mem.mem_ack & mem_req_q;
    assign tmo_hit_s  = (tmo_q == TW'(ACK_TIMEOUT - 1));
    assign dma_win_s  = dma_req_i & (starve_q == SW'(STARVE_LIMIT));

    // Next-state, memory-bus and completion logic.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        ld_size_d    = ld_size_q;
        ld_off_d     = ld_off_q;
        pipe_done_d  = 1'b0;
        misalign_d   = 1'b0;
        dma_done_d   = 1'b0;
        pipe_rdata_d = pipe_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        pipe_gnt_s   = 1'b0;
        dma_gnt_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A pending pipeline request holds off DMA unless DMA is starved;
                // the PipeDone cycle only blocks re-issue of the finished access.
                if (pipe_req_s && !dma_win_s) begin
                    if (pipe_done_q) begin
                        state_d = S_IDLE;
                    end else if (misalign_s) begin
                        state_d      = S_ERR;
                        pipe_done_d  = 1'b1;
                        misalign_d   = 1'b1;
                        pipe_rdata_d = 32'h0000_0000;
                    end else begin
                        pipe_gnt_s  = 1'b1;
                        state_d     = S_PIPE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write_i;
                        mem_addr_d  = {alu_result_i[31:2], 2'b00};
                        mem_wdata_d = st_data_s;
                        mem_be_d    = be_s;
                        ld_size_d   = bit_sel_i;
                        ld_off_d    = alu_result_i[1:0];
                        tmo_d       = {TW{1'b0}};
                    end
                end else if (dma_req_i) begin
                    dma_gnt_s   = 1'b1;
                    state_d     = S_DMA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dma_we_i;
                    mem_addr_d  = {dma_addr_i[31:2], 2'b00};
                    mem_wdata_d = dma_wdata_i;
                    mem_be_d    = 4'b1111;
                    tmo_d       = {TW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PIPE: begin
                if (ack_s) begin
                    state_d      = S_IDLE;
                    mem_req_d    = 1'b0;
                    tmo_d        = {TW{1'b0}};
                    pipe_done_d  = 1'b1;
                    pipe_rdata_d = mem_we_q ? 32'h0000_0000 : ld_data_s;
                end else if (tmo_hit_s) begin
                    state_d      = S_IDLE;
                    mem_req_d    = 1'b0;
                    tmo_d        = {TW{1'b0}};
                    pipe_done_d  = 1'b1;
                    misalign_d   = 1'b1;
                    pipe_rdata_d = 32'h0000_0000;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DMA: begin
                if (ack_s) begin
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                    tmo_d       = {TW{1'b0}};
                    dma_done_d  = 1'b1;
                    dma_rdata_d = mem_we_q ? 32'h0000_0000 : mem.mem_rdata;
                end else if (tmo_hit_s) begin
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                    tmo_d       = {TW{1'b0}};
                    dma_done_d  = 1'b1;
                    dma_rdata_d = 32'h0000_0000;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!dma_req_i || dma_gnt_s) begin
            starve_d = {SW{1'b0}};
        end else if (pipe_gnt_s && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            starve_q     <= {SW{1'b0}};
            tmo_q        <= {TW{1'b0}};
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_be_q     <= 4'b0000;
            ld_size_q    <= SZ_WORD;
            ld_off_q     <= 2'b00;
            pipe_done_q  <= 1'b0;
            pipe_rdata_q <= 32'h0000_0000;
            misalign_q   <= 1'b0;
            dma_done_q   <= 1'b0;
            dma_rdata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            tmo_q        <= tmo_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            ld_size_q    <= ld_size_d;
            ld_off_q     <= ld_off_d;
            pipe_done_q  <= pipe_done_d;
            pipe_rdata_q <= pipe_rdata_d;
            misalign_q   <= misalign_d;
            dma_done_q   <= dma_done_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign pipe_stall_o   = pipe_req_s & ~pipe_done_q;
    assign pipe_done_o    = pipe_done_q;
    assign pipe_rdata_o   = pipe_rdata_q;
    assign misalign_err_o = misalign_q;
    assign dma_gnt_o      = (state_q == S_DMA);
    assign dma_done_o     = dma_done_q;
    assign dma_rdata_o    = dma_rdata_q;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table for lane handling plus
// sequences for latency, starvation, timeout and reset in flight.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, dma_req, dma_we;
    logic [31:0] alu_result, rt, dma_addr, dma_wdata;
    logic [1:0]  bit_sel;
    logic        pipe_stall, pipe_done, misalign_err, dma_gnt, dma_done;
    logic [31:0] pipe_rdata, dma_rdata;

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(.STARVE_LIMIT(4), .ACK_TIMEOUT(15)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .alu_result_i(alu_result),
        .rt_i(rt), .bit_sel_i(bit_sel),
        .pipe_stall_o(pipe_stall), .pipe_done_o(pipe_done), .pipe_rdata_o(pipe_rdata),
        .misalign_err_o(misalign_err),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_gnt_o(dma_gnt), .dma_done_o(dma_done), .dma_rdata_o(dma_rdata),
        .mem(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        chk_rd;
    } pipe_exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [1:0]  sz;
        logic [31:0] mrdata;
        logic        mis;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] erd;
        logic        chk_rd;
    } vec_t;

    mem_exp_t    exp_mem_q[$];
    pipe_exp_t   exp_pipe_q[$];
    logic [31:0] exp_dma_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_delay = 1;
    logic [31:0] mem_word = 32'h0;
    bit          stray_ack = 1'b0;
    int          req_rises = 0;
    int          wait_cnt = 0;
    logic        prev_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acks ack_delay cycles after MemReq rises and scores the bus fields.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (!prev_req) begin
                wait_cnt = 0;
                req_rises++;
            end else begin
                wait_cnt++;
            end
            if (ack_delay >= 0 && wait_cnt == ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_word;
                if (exp_mem_q.size() == 0) begin
                    check("mem_unexpected", 32'd1, 32'd0);
                end else begin
                    mem_exp_t e;
                    e = exp_mem_q.pop_front();
                    check("mem_addr", bus.mem_addr, e.addr);
                    check("mem_be", {28'h0, bus.mem_be}, {28'h0, e.be});
                    check("mem_wdata", bus.mem_wdata, e.wdata);
                    check("mem_we", {31'h0, bus.mem_we}, {31'h0, e.we});
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
        end else begin
            bus.mem_ack = stray_ack;
        end
        prev_req = bus.mem_req;
    end

    // Completion monitor for both requesters.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pipe_done === 1'b1) begin
                if (exp_pipe_q.size() == 0) begin
                    check("pipe_done_unexpected", 32'd1, 32'd0);
                end else begin
                    pipe_exp_t p;
                    p = exp_pipe_q.pop_front();
                    if (p.chk_rd) check("pipe_rdata", pipe_rdata, p.rdata);
                    check("misalign_err", {31'h0, misalign_err}, {31'h0, p.mis});
                    check("stall_at_done", {31'h0, pipe_stall}, 32'd0);
                end
            end
            if (dma_done === 1'b1) begin
                if (exp_dma_q.size() == 0) begin
                    check("dma_done_unexpected", 32'd1, 32'd0);
                end else begin
                    check("dma_rdata", dma_rdata, exp_dma_q.pop_front());
                end
            end
        end
    end

    task automatic wait_pipe_done();
        int k = 0;
        while (pipe_done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("pipe_done_wait", 32'd0, 32'd1);
    endtask

    task automatic run_timeout(input bit is_dma);
        int hi = 0;
        int g = 0;
        ack_delay = -1;
        if (is_dma) begin
            exp_dma_q.push_back(32'h0);
            dma_addr = 32'h80; dma_we = 1'b0; dma_req = 1'b1;
        end else begin
            exp_pipe_q.push_back('{32'h0, 1'b1, 1'b1});
            alu_result = 32'h600; bit_sel = 2'b00; mem_read = 1'b1;
        end
        while (bus.mem_req !== 1'b1 && g < 10) begin @(negedge clk); g++; end
        while (bus.mem_req === 1'b1 && g < 60) begin hi++; @(negedge clk); g++; end
        check(is_dma ? "dma_timeout_len" : "pipe_timeout_len", hi, 32'd15);
        check("timeout_done", {31'h0, is_dma ? dma_done : pipe_done}, 32'd1);
        dma_req = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        ack_delay = 1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h103, 32'h0000_00AB, 2'b10, 32'h0,         1'b0, 32'h100, 4'b1000, 32'hABAB_ABAB, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h202, 32'h0,         2'b01, 32'h8765_4321, 1'b0, 32'h200, 4'b1100, 32'h0,         32'h0000_8765, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h101, 32'h0,         2'b10, 32'h1122_3344, 1'b0, 32'h100, 4'b0010, 32'h0,         32'h0000_0033, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 2'b00, 32'h0,         1'b0, 32'h200, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h000, 32'h1234_5678, 2'b01, 32'h0,         1'b0, 32'h000, 4'b0011, 32'h5678_5678, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h300, 32'h0,         2'b11, 32'hCAFE_F00D, 1'b0, 32'h300, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h101, 32'h0,         2'b00, 32'h0,         1'b1, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h203, 32'h1,         2'b01, 32'h0,         1'b1, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[8]  = '{1'b1, 1'b1, 32'h400, 32'h0F0F_0F0F, 2'b00, 32'h0,         1'b0, 32'h400, 4'b1111, 32'h0F0F_0F0F, 32'h0,         1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h003, 32'h0,         2'b10, 32'hA1B2_C3D4, 1'b0, 32'h000, 4'b1000, 32'h0,         32'h0000_00A1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h002, 32'h0000_005A, 2'b10, 32'h0,         1'b0, 32'h000, 4'b0100, 32'h5A5A_5A5A, 32'h0,         1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h004, 32'h0,         2'b01, 32'hFFEE_1122, 1'b0, 32'h004, 4'b0011, 32'h0,         32'h0000_1122, 1'b1};

        rst_n = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h0; rt = 32'h0; bit_sel = 2'b00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        #2;
        check("rst_mem_req", {31'h0, bus.mem_req}, 32'd0);
        check("rst_mem_be", {28'h0, bus.mem_be}, 32'd0);
        check("rst_dma_gnt", {31'h0, dma_gnt}, 32'd0);
        check("rst_pipe_done", {31'h0, pipe_done}, 32'd0);
        check("rst_misalign", {31'h0, misalign_err}, 32'd0);
        check("rst_pipe_rdata", pipe_rdata, 32'd0);
        check("rst_stall_follows_req", {31'h0, pipe_stall}, 32'd1);
        mem_read = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Minimum latency: request -> MemReq -> same-cycle ack -> done, 2 cycles.
        begin
            int cyc = 0;
            ack_delay = 0; mem_word = 32'h0000_0001;
            exp_mem_q.push_back('{32'h10, 1'b0, 4'b1111, 32'h0});
            exp_pipe_q.push_back('{32'h0000_0001, 1'b0, 1'b1});
            alu_result = 32'h10; bit_sel = 2'b00; rt = 32'h0; mem_read = 1'b1;
            while (pipe_done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
            check("min_latency", cyc, 32'd2);
            mem_read = 1'b0;
            @(negedge clk);
        end

        for (int i = 0; i < 12; i++) begin
            int rises0;
            ack_delay = i % 3;
            mem_word = vecs[i].mrdata;
            if (!vecs[i].mis)
                exp_mem_q.push_back('{vecs[i].eaddr, vecs[i].wr, vecs[i].ebe, vecs[i].ewd});
            exp_pipe_q.push_back('{vecs[i].erd, vecs[i].mis, vecs[i].chk_rd});
            rises0 = req_rises;
            mem_read = vecs[i].rd; mem_write = vecs[i].wr;
            alu_result = vecs[i].addr; rt = vecs[i].rt; bit_sel = vecs[i].sz;
            wait_pipe_done();
            mem_read = 1'b0; mem_write = 1'b0;
            if (vecs[i].mis) check("misalign_no_memreq", req_rises - rises0, 32'd0);
            @(negedge clk);
        end

        // Standalone DMA read with low address bits set.
        begin
            int g = 0;
            ack_delay = 1; mem_word = 32'h55AA_55AA;
            exp_mem_q.push_back('{32'h1234, 1'b0, 4'b1111, 32'h0});
            exp_dma_q.push_back(32'h55AA_55AA);
            dma_addr = 32'h1237; dma_we = 1'b0; dma_wdata = 32'h0; dma_req = 1'b1;
            @(negedge clk);
            check("dma_gnt_high", {31'h0, dma_gnt}, 32'd1);
            while (dma_done !== 1'b1 && g < 50) begin @(negedge clk); g++; end
            check("dma_done_seen", {31'h0, dma_done}, 32'd1);
            dma_req = 1'b0;
            @(negedge clk);
            check("dma_gnt_low", {31'h0, dma_gnt}, 32'd0);
        end

        // Starvation: both sides hold requests; expect P x4, D, P x4, D.
        begin
            int g = 0;
            int nd = 0;
            int np = 0;
            ack_delay = 1; mem_word = 32'h0BAD_F00D;
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < 4; k++) begin
                    exp_mem_q.push_back('{32'h500, 1'b0, 4'b1111, 32'h0});
                    exp_pipe_q.push_back('{32'h0BAD_F00D, 1'b0, 1'b1});
                end
                exp_mem_q.push_back('{32'h40, 1'b0, 4'b1111, 32'h0});
                exp_dma_q.push_back(32'h0BAD_F00D);
            end
            dma_addr = 32'h42; dma_we = 1'b0; dma_req = 1'b1;
            alu_result = 32'h500; bit_sel = 2'b00; rt = 32'h0; mem_read = 1'b1;
            while (nd < 2 && g < 400) begin
                @(negedge clk);
                g++;
                if (pipe_done === 1'b1) np++;
                if (dma_done === 1'b1) nd++;
            end
            dma_req = 1'b0; mem_read = 1'b0;
            check("starve_dma_count", nd, 32'd2);
            check("starve_pipe_count", np, 32'd8);
            @(negedge clk);
        end

        run_timeout(1'b0);
        run_timeout(1'b1);

        // Reset in the middle of a DMA access, then a stray ack after release.
        begin
            int g = 0;
            ack_delay = -1;
            dma_addr = 32'h90; dma_we = 1'b0; dma_req = 1'b1;
            while (dma_gnt !== 1'b1 && g < 20) begin @(negedge clk); g++; end
            repeat (3) @(negedge clk);
            #2;
            rst_n = 1'b0; stray_ack = 1'b1; dma_req = 1'b0;
            #1;
            check("midrst_mem_req", {31'h0, bus.mem_req}, 32'd0);
            check("midrst_dma_gnt", {31'h0, dma_gnt}, 32'd0);
            check("midrst_mem_addr", bus.mem_addr, 32'd0);
            check("midrst_mem_be", {28'h0, bus.mem_be}, 32'd0);
            check("midrst_dma_done", {31'h0, dma_done}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            check("post_rst_mem_req", {31'h0, bus.mem_req}, 32'd0);
            check("post_rst_dma_done", {31'h0, dma_done}, 32'd0);
            check("post_rst_dma_gnt", {31'h0, dma_gnt}, 32'd0);
            stray_ack = 1'b0;
            @(negedge clk);
            ack_delay = 1; mem_word = 32'h1357_9BDF;
            exp_mem_q.push_back('{32'h700, 1'b0, 4'b1111, 32'h0});
            exp_pipe_q.push_back('{32'h1357_9BDF, 1'b0, 1'b1});
            alu_result = 32'h700; bit_sel = 2'b00; mem_read = 1'b1;
            wait_pipe_done();
            mem_read = 1'b0;
        end

        repeat (5) @(negedge clk);
        check("mem_exp_left", exp_mem_q.size(), 32'd0);
        check("pipe_exp_left", exp_pipe_q.size(), 32'd0);
        check("dma_exp_left", exp_dma_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): STARVE_LIMIT, 4, consecutive pipeline grants allowed while DMA waits.
REQ-002 The module SHALL have these parameters (name, default, meaning): ACK_TIMEOUT, 15, cycles without MemAck before an access aborts.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Pipeline side: MemRead, MemWrite  input  1 each  MEM-stage access request.
REQ-006 Pipeline side: ALUResult  input  32  byte address.
REQ-007 Pipeline side: Rt  input  32  store data.
REQ-008 Pipeline side: BitSel  input  2  access size (00 word, 01 half, 10 byte, 11 treated as word).
REQ-009 PipeStall  output  1  holds the pipeline.
REQ-010 PipeDone  output  1  one-cycle completion pulse.
REQ-011 PipeRdata  output  32  load data, right-justified, zero-extended.
REQ-012 MisalignErr  output  1  one-cycle pulse.
REQ-013 DMA side: DmaReq, DmaWe  input  1 each  request and write enable.
REQ-014 DMA side: DmaAddr  input  32  word address, bits [1:0] ignored.
REQ-015 DMA side: DmaWdata  input  32  write data.
REQ-016 DMA side: DmaGnt, DmaDone  output  1 each  grant and completion pulse.
REQ-017 DMA side: DmaRdata  output  32  read data.
REQ-018 Memory side: MemReq, MemWe  output  1 each  request and write enable.
REQ-019 Memory side: MemAddr  output  32  word-aligned, bits [1:0]=0.
REQ-020 Memory side: MemWdata  output  32  lane-aligned write data.
REQ-021 Memory side: MemBe  output  4  byte enables.
REQ-022 Memory side: MemRdata  input  32  read data.
REQ-023 Memory side: MemAck  input  1  access complete; valid only while MemReq=1.

Function
REQ-024 The FSM SHALL have states IDLE, PIPE, DMA and ERR; ERR lasts one cycle, then the FSM returns to IDLE.
REQ-025 IDLE SHALL grant the pipeline when MemRead|MemWrite=1, unless DMA wins by REQ-026; otherwise it SHALL grant DMA on DmaReq=1.
REQ-026 DMA SHALL win when DmaReq=1 and the starvation counter equals STARVE_LIMIT.
REQ-027 The starvation counter SHALL increment on each pipeline grant while DmaReq=1, and SHALL clear on a DMA grant or whenever DmaReq=0.
REQ-028 IDLE SHALL NOT accept a pipeline request in a cycle where PipeDone=1; this prevents the completed access being re-issued.
REQ-029 MemReq SHALL be registered, high in PIPE and DMA, with MemAddr, MemWe, MemWdata and MemBe held stable until MemAck.
REQ-030 On MemAck, the FSM SHALL go to IDLE and MemReq SHALL fall.
REQ-031 On MemAck in PIPE, the next cycle SHALL have PipeDone=1 with registered PipeRdata.
REQ-032 On MemAck in DMA, the next cycle SHALL have DmaDone=1 with registered DmaRdata.
REQ-033 PipeStall SHALL be combinational: (MemRead|MemWrite) & ~PipeDone.
REQ-034 DmaGnt SHALL be 1 exactly while state=DMA.
REQ-035 Minimum latency SHALL be: request in IDLE -> MemReq next cycle -> MemAck same cycle earliest -> Done the cycle after that, i.e. 2 cycles.
REQ-036 Lanes, byte access: MemBe = 1<<addr[1:0]; MemWdata = Rt[7:0] replicated 4x.
REQ-037 Lanes, half access: MemBe = addr[1] ? 1100 : 0011; MemWdata = Rt[15:0] replicated 2x.
REQ-038 Lanes, word access: MemBe = 1111; MemWdata = Rt.
REQ-039 For a DMA access, MemBe SHALL be 1111.
REQ-040 Loads SHALL extract the addressed lane and zero-extend it into PipeRdata.
REQ-041 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL issue no memory access; the FSM SHALL go IDLE -> ERR -> IDLE.
REQ-042 A misaligned access SHALL pulse PipeDone and MisalignErr together, with PipeRdata=0.
REQ-043 MemRead and MemWrite both high SHALL be treated as a write.
REQ-044 A timeout counter SHALL start when MemReq rises and clear on MemAck.
REQ-045 On reaching ACK_TIMEOUT, the access SHALL be dropped: MemReq low, and Done plus MisalignErr pulsed (pipeline) or DmaDone pulsed with DmaRdata=0 (DMA).
REQ-046 MemAck while MemReq=0 SHALL be ignored.

Reset
REQ-047 Rst_n=0 SHALL immediately force state IDLE and clear both counters.
REQ-048 Rst_n=0 SHALL immediately force all outputs to 0, except PipeStall, which follows REQ-033.
REQ-049 An access in flight at reset SHALL be abandoned; a late MemAck after reset release SHALL be ignored per REQ-046.

Structure
REQ-050 Package mem_arb_pkg SHALL hold the state encoding, the BitSel codes (SZ_WORD, SZ_HALF, SZ_BYTE) and the STARVE_LIMIT/ACK_TIMEOUT defaults.
REQ-051 Combinational sub-module mem_lane_align SHALL compute MemBe, aligned write data, load extraction and the misalign flag.

Verification
REQ-052 Byte store: BitSel=10, ALUResult=0x103, Rt=0xAB, MemAck 1 cycle after MemReq -> MemAddr=0x100, MemBe=1000, MemWdata=0xABABABAB, PipeDone 1 cycle after ack, PipeStall low that cycle.
REQ-053 Half load: ALUResult=0x202, MemRdata=0x8765_4321 -> PipeRdata=0x0000_8765.
REQ-054 Starvation: pipeline requests continuously and DmaReq held high -> DMA granted after exactly 4 pipeline accesses; the counter clears afterwards.
REQ-055 Misaligned word at 0x101 -> no MemReq, PipeDone=MisalignErr=1 for one cycle, PipeRdata=0.
REQ-056 Timeout: MemAck never asserted -> MemReq drops 15 cycles after rising, Done pulses; Rst_n pulsed low mid-DMA -> all outputs 0 at once, FSM IDLE.
